// File: rtl/inj_queue_pkg.sv
// Shared hring definitions: flit width, valid bit position and the
// injection-queue state encoding.
package inj_queue_pkg;

  localparam int CONTROL_W = 144;
  localparam int VALID_BIT = CONTROL_W - 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_OFFER,
    ST_BLOCKED
  } state_t;

  function automatic logic [CONTROL_W-1:0] mark_valid(
    input logic [CONTROL_W-1:0] f
  );
    logic [CONTROL_W-1:0] r;
    r = f;
    r[VALID_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/inj_fifo_mem.sv
// Flit storage for the injection queue: one write port, one
// asynchronous read port, no reset on the array.
module inj_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 144
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inj_queue.sv
// Local-core injection queue feeding a router local port, with a
// head-of-line wait counter that flags starvation.
module inj_queue
  import inj_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CONTROL_W-1:0]       enq_flit,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  output logic [CONTROL_W-1:0]       portl_co,
  input  logic                       portl_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [7:0]    LIMIT = 8'(STARVE_LIMIT);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [7:0]           wait_cnt;
  logic [CONTROL_W-1:0] head;
  logic [CONTROL_W-1:0] wdata;
  logic                 empty;
  logic                 push;
  logic                 pop;
  state_t               state;
  state_t               state_nx;

  assign empty     = (count == '0);
  assign enq_ready = (count < FULL);
  assign push      = enq_valid & enq_ready;
  assign pop       = ~empty & portl_ack;
  assign wdata     = mark_valid(enq_flit);
  // Gate stale storage so an empty queue never shows a valid flit.
  assign portl_co  = empty ? '0 : head;
  assign starve    = (wait_cnt >= LIMIT);

  inj_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (CONTROL_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_EMPTY: begin
        if (push) state_nx = ST_OFFER;
      end
      ST_OFFER, ST_BLOCKED: begin
        if (!pop)
          state_nx = ST_BLOCKED;
        else if (count > ONE || push)
          state_nx = ST_OFFER;
        else
          state_nx = ST_EMPTY;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pop || state != ST_BLOCKED)
        wait_cnt <= '0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inj_queue.sv
// Scoreboard bench for inj_queue: stimulus queues expected flits,
// a negedge monitor checks every acknowledged head flit.
module tb_inj_queue;
  import inj_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic [CONTROL_W-1:0] enq_flit;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [CONTROL_W-1:0] portl_co;
  logic                 portl_ack;
  logic [CW-1:0]        count;
  logic                 starve;

  int total;
  int fails;
  int mcount;
  logic [CONTROL_W-1:0] exp_q[$];
  logic [CONTROL_W-1:0] vmask;
  logic [CONTROL_W-1:0] f0;

  inj_queue #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_flit  (enq_flit),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .portl_co  (portl_co),
    .portl_ack (portl_ack),
    .count     (count),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [CONTROL_W-1:0] act,
                     input logic [CONTROL_W-1:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [CONTROL_W-1:0] mk(input int i);
    return {16'h0, {4{32'(i) + 32'hC0DE_0000}}};
  endfunction

  // Drive one cycle at posedge+1, hold over the next edge, update model.
  task automatic cycle(input logic v,
                       input logic [CONTROL_W-1:0] f,
                       input logic a);
    logic p;
    logic q;
    enq_valid = v;
    enq_flit  = f;
    portl_ack = a;
    p = v && (mcount < DEPTH);
    q = a && (mcount > 0);
    if (p) exp_q.push_back(f | vmask);
    @(posedge clk);
    #1;
    mcount = mcount + int'(p) - int'(q);
  endtask

  task automatic chk_cnt(input string name);
    chk(name, CONTROL_W'(count), CONTROL_W'(mcount));
  endtask

  always @(negedge clk) begin
    if (rst && portl_ack && portl_co[VALID_BIT]) begin
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $display("FAIL pop_unexpected: got %h want none", portl_co);
      end else begin
        chk("pop_order", portl_co, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    fails = 0;
    mcount = 0;
    vmask = '0;
    vmask[VALID_BIT] = 1'b1;
    f0 = 144'h0aaaaaaaaaabcdef0123456789abcdef1857;
    rst = 1'b0;
    enq_valid = 1'b0;
    enq_flit = '0;
    portl_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_count", CONTROL_W'(count), '0);
    chk("rst_ready", CONTROL_W'(enq_ready), 144'd1);
    chk("rst_co", portl_co, '0);
    chk("rst_starve", CONTROL_W'(starve), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    cycle(1'b1, f0, 1'b0);
    chk("first_co", portl_co, f0 | vmask);
    chk_cnt("first_count");
    cycle(1'b0, '0, 1'b1);
    chk_cnt("first_drain");

    for (int i = 0; i < 4; i++) cycle(1'b1, mk(i), 1'b0);
    chk_cnt("full_count");
    chk("full_ready", CONTROL_W'(enq_ready), '0);
    cycle(1'b1, mk(99), 1'b0);
    chk_cnt("full_reject");
    cycle(1'b1, mk(98), 1'b1);
    chk("full_pushpop", CONTROL_W'(count), 144'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk_cnt("full_drain");

    cycle(1'b1, mk(10), 1'b0);
    cycle(1'b1, mk(11), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(20 + i), 1'b1);
      chk("wrap_count", CONTROL_W'(count), 144'd2);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk_cnt("wrap_drain");

    cycle(1'b1, mk(40), 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b0);
    chk("starve_pre", CONTROL_W'(starve), '0);
    cycle(1'b0, '0, 1'b0);
    chk("starve_rise", CONTROL_W'(starve), 144'd1);
    chk("starve_head", portl_co, mk(40) | vmask);
    cycle(1'b0, '0, 1'b1);
    chk("starve_fall", CONTROL_W'(starve), '0);
    chk_cnt("starve_empty");

    for (int i = 0; i < 3; i++) cycle(1'b1, mk(50 + i), 1'b0);
    chk("mid_count", CONTROL_W'(count), 144'd3);
    enq_valid = 1'b0;
    portl_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", CONTROL_W'(count), '0);
    chk("mid_rst_co", portl_co, '0);
    chk("mid_rst_ready", CONTROL_W'(enq_ready), 144'd1);
    chk("mid_rst_starve", CONTROL_W'(starve), '0);
    exp_q.delete();
    mcount = 0;
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b1);
    chk_cnt("empty_ack_count");
    chk("empty_ack_co", portl_co, '0);
    cycle(1'b1, mk(60) | vmask, 1'b0);
    chk("post_rst_co", portl_co, mk(60) | vmask);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk_cnt("final_count");
    chk("sb_empty", CONTROL_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
